uart_rx: RTL and testbench

- Serial UART receive deframer. Frame format is 8N1: one start bit (low), DATA_BITS data bits LSB first, one stop bit (high).
- One line sample is taken per bit period, on each cycle where the bit-rate strobe i_CLK_ENABLE is high. There is no oversampling.
- Sits between an external baud-tick generator / RX synchronizer and a byte consumer (FIFO or register file).
- Delivers the assembled byte with a one-cycle done pulse. Reports stop-bit violations on a framing-error pulse.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx.sv | 84 ++++++++
 tb/tb_uart_rx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame state encoding and default width.
package uart_pkg;

  localparam int UART_DEFAULT_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA      = 2'd1,
    STOP      = 2'd2,
    WAIT_IDLE = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1-style UART deframer: one line sample per bit-rate strobe, LSB-first data,
// one-cycle done / framing-error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DEFAULT_DATA_BITS
) (
  input  logic                 i_CLK,
  input  logic                 i_RESET,
  input  logic                 i_CLK_ENABLE,
  input  logic                 i_RX,
  output logic [DATA_BITS-1:0] o_DATA,
  output logic                 o_RX_DONE,
  output logic                 o_FRAMING_ERROR,
  output logic [1:0]           o_STATE
);

  localparam logic [1:0] S_IDLE      = IDLE;
  localparam logic [1:0] S_DATA      = DATA;
  localparam logic [1:0] S_STOP      = STOP;
  localparam logic [1:0] S_WAIT_IDLE = WAIT_IDLE;
  localparam logic [3:0] CNT_LAST    = 4'(DATA_BITS - 1);

  logic [1:0]           state;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;

  // Right shift with the new sample entering at the MSB; written this way so
  // a single-bit frame needs no special case.
  always_comb begin
    shift_next                = shift_reg >> 1;
    shift_next[DATA_BITS-1]   = i_RX;
  end

  // Pulses default low every clock, so they last exactly one cycle no matter
  // how far apart the strobes are.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state           <= S_IDLE;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      o_DATA          <= '0;
      o_RX_DONE       <= 1'b0;
      o_FRAMING_ERROR <= 1'b0;
    end else begin
      o_RX_DONE       <= 1'b0;
      o_FRAMING_ERROR <= 1'b0;
      if (i_CLK_ENABLE) begin
        case (state)
          S_IDLE: begin
            if (!i_RX) begin
              bit_cnt <= '0;
              state   <= S_DATA;
            end
          end
          S_DATA: begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + 4'd1;
            if (bit_cnt == CNT_LAST) state <= S_STOP;
          end
          S_STOP: begin
            if (i_RX) begin
              o_DATA    <= shift_reg;
              o_RX_DONE <= 1'b1;
              state     <= S_IDLE;
            end else begin
              o_FRAMING_ERROR <= 1'b1;
              state           <= S_WAIT_IDLE;
            end
          end
          default: begin
            // Line held low after a bad stop bit: wait for it to return high
            // so the break itself is never mistaken for a start bit.
            if (i_RX) state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_STATE = state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: stimulus pushes expected bytes into a queue, a
// separate monitor pops and compares on every done / framing-error pulse.
module tb_uart_rx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         rx;
  logic [W-1:0] o_data;
  logic         o_done;
  logic         o_fe;
  logic [1:0]   o_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  int           fe_exp = 0;
  logic [W-1:0] last_good = '0;
  logic         done_d = 1'b0;

  uart_rx #(.DATA_BITS(W)) dut (
    .i_CLK          (clk),
    .i_RESET        (rst),
    .i_CLK_ENABLE   (en),
    .i_RX           (rx),
    .o_DATA         (o_data),
    .o_RX_DONE      (o_done),
    .o_FRAMING_ERROR(o_fe),
    .o_STATE        (o_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (o_done) begin
        check("done_width", {31'd0, done_d}, 32'd0);
        check("done_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("rx_data", o_data, e);
          last_good = e;
        end
      end
      if (o_fe) begin
        check("fe_expected", (fe_exp > 0) ? 32'd1 : 32'd0, 32'd1);
        if (fe_exp > 0) fe_exp--;
        check("fe_data_hold", o_data, last_good);
      end
    end
    done_d = o_done;
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_bit(input logic b, input int gmax);
    int gap;
    rx = b;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    gap = (gmax > 0) ? int'($urandom_range(1, gmax)) : 0;
    repeat (gap) begin
      rx = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  // Start + data bits; the stop strobe is issued here and its pulse checked
  // on the negedge right after the strobe edge.
  task automatic send_frame(input logic [W-1:0] d, input logic stop, input int gmax);
    send_bit(1'b0, gmax);
    for (int i = 0; i < W; i++) send_bit(d[i], gmax);
    if (stop) exp_q.push_back(d);
    else fe_exp++;
    rx = stop;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    if (stop) check("done_latency", {31'd0, o_done}, 32'd1);
    else      check("fe_latency", {31'd0, o_fe}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    en  = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", o_data, 32'h00);
    check("reset_state", {30'd0, o_state}, 32'd0);
    check("reset_pulses", {30'd0, o_done, o_fe}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Idle line: 20 strobes of high line
    for (int i = 0; i < 20; i++) begin
      rx = 1'b1;
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
    end
    check("idle_state", {30'd0, o_state}, 32'd0);
    check("idle_data", o_data, 32'h00);

    // Good frame 0xA5, continuous strobes
    send_frame(8'hA5, 1'b1, 0);
    rx = 1'b1;
    @(negedge clk);
    check("a5_pulse_gone", {31'd0, o_done}, 32'd0);
    check("a5_hold", o_data, 32'hA5);

    // Framing error on 0x3C, line held low for 3 strobes then high
    send_frame(8'h3C, 1'b0, 0);
    check("fe_state", {30'd0, o_state}, 32'd3);
    rx = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b0, 0);
      check("break_no_start", {30'd0, o_state}, 32'd3);
    end
    send_bit(1'b1, 0);
    check("break_release_idle", {30'd0, o_state}, 32'd0);
    check("fe_data_kept", o_data, 32'hA5);

    // Same 0xA5 frame with 1..5 clock gaps and a toggling line between strobes
    send_frame(8'hA5, 1'b1, 5);
    rx = 1'b1;
    send_bit(1'b1, 2);
    check("gap_state", {30'd0, o_state}, 32'd0);

    // Reset mid-frame after 4 data bits: asynchronous clear
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    check("midframe_state", {30'd0, o_state}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_data", o_data, 32'h00);
    check("async_rst_state", {30'd0, o_state}, 32'd0);
    check("async_rst_pulses", {30'd0, o_done, o_fe}, 32'd0);
    last_good = '0;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    @(negedge clk);
    send_frame(8'h5A, 1'b1, 0);

    // Back-to-back 0x01 then 0xFF, start follows stop strobe directly
    send_frame(8'h01, 1'b1, 0);
    check("b2b_first", o_data, 32'h01);
    send_frame(8'hFF, 1'b1, 0);
    check("b2b_second", o_data, 32'hFF);
    rx = 1'b1;
    repeat (4) @(negedge clk);

    check("pending_bytes", exp_q.size(), 32'd0);
    check("pending_fe", fe_exp, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
